// File: rtl/riscv_pkg.sv
// Shared encodings for the core's pipeline hazard control.
package riscv_pkg;

   localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   typedef enum logic {
      S_RUN   = 1'b0,
      S_STALL = 1'b1
   } hz_state_e;

endpackage

// File: rtl/hazard_shadow_pipe.sv
// Shadow copy of the EX/MEM/WB register fields the hazard unit needs.
// EX captures the ID-stage decode (or a bubble); MEM and WB follow EX.
module hazard_shadow_pipe #(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_bubble,
   input  logic [REG_ADDR_W-1:0] i_rs1_ID,
   input  logic [REG_ADDR_W-1:0] i_rs2_ID,
   input  logic [REG_ADDR_W-1:0] i_rd_ID,
   input  logic                  i_reg_write_ID,
   input  logic [1:0]            i_result_src_ID,
   output logic [REG_ADDR_W-1:0] o_rs1_EX,
   output logic [REG_ADDR_W-1:0] o_rs2_EX,
   output logic [REG_ADDR_W-1:0] o_rd_EX,
   output logic                  o_reg_write_EX,
   output logic [1:0]            o_result_src_EX,
   output logic [REG_ADDR_W-1:0] o_rd_MEM,
   output logic                  o_reg_write_MEM,
   output logic [REG_ADDR_W-1:0] o_rd_WB,
   output logic                  o_reg_write_WB
);

   logic [REG_ADDR_W-1:0] rs1_ex_q, rs1_ex_d, rs2_ex_q, rs2_ex_d, rd_ex_q, rd_ex_d;
   logic                  rw_ex_q, rw_ex_d;
   logic [1:0]            src_ex_q, src_ex_d;
   logic [REG_ADDR_W-1:0] rd_mem_q, rd_mem_d, rd_wb_q, rd_wb_d;
   logic                  rw_mem_q, rw_mem_d, rw_wb_q, rw_wb_d;

   // Next shadow contents: EX takes ID or a zeroed bubble, older stages shift.
   always_comb begin
      rs1_ex_d = i_rs1_ID;
      rs2_ex_d = i_rs2_ID;
      rd_ex_d  = i_rd_ID;
      rw_ex_d  = i_reg_write_ID;
      src_ex_d = i_result_src_ID;
      if (i_bubble) begin
         rs1_ex_d = '0;
         rs2_ex_d = '0;
         rd_ex_d  = '0;
         rw_ex_d  = 1'b0;
         src_ex_d = '0;
      end
      rd_mem_d = rd_ex_q;
      rw_mem_d = rw_ex_q;
      rd_wb_d  = rd_mem_q;
      rw_wb_d  = rw_mem_q;
   end

   // Shadow registers, cleared by synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rs1_ex_q <= '0;
         rs2_ex_q <= '0;
         rd_ex_q  <= '0;
         rw_ex_q  <= 1'b0;
         src_ex_q <= '0;
         rd_mem_q <= '0;
         rw_mem_q <= 1'b0;
         rd_wb_q  <= '0;
         rw_wb_q  <= 1'b0;
      end else begin
         rs1_ex_q <= rs1_ex_d;
         rs2_ex_q <= rs2_ex_d;
         rd_ex_q  <= rd_ex_d;
         rw_ex_q  <= rw_ex_d;
         src_ex_q <= src_ex_d;
         rd_mem_q <= rd_mem_d;
         rw_mem_q <= rw_mem_d;
         rd_wb_q  <= rd_wb_d;
         rw_wb_q  <= rw_wb_d;
      end
   end

   assign o_rs1_EX        = rs1_ex_q;
   assign o_rs2_EX        = rs2_ex_q;
   assign o_rd_EX         = rd_ex_q;
   assign o_reg_write_EX  = rw_ex_q;
   assign o_result_src_EX = src_ex_q;
   assign o_rd_MEM        = rd_mem_q;
   assign o_reg_write_MEM = rw_mem_q;
   assign o_rd_WB         = rd_wb_q;
   assign o_reg_write_WB  = rw_wb_q;

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush/forwarding control for the 5-stage core.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_RUN   | normal issue; a load-use hit stalls this cycle
//   S_STALL | extra load-use bubbles; cnt counts the remaining ones
module hazard_unit
   import riscv_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int LOAD_STALL = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [REG_ADDR_W-1:0] i_rs1_ID,
   input  logic [REG_ADDR_W-1:0] i_rs2_ID,
   input  logic [REG_ADDR_W-1:0] i_rd_ID,
   input  logic                  i_reg_write_ID,
   input  logic [1:0]            i_result_src_ID,
   input  logic                  i_pc_src_EX,
   output logic                  o_stall_IF,
   output logic                  o_stall_ID,
   output logic                  o_flush_ID,
   output logic                  o_flush_EX,
   output logic [1:0]            o_forwardA_EX,
   output logic [1:0]            o_forwardB_EX
);

   logic [REG_ADDR_W-1:0] rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
   logic                  rw_ex, rw_mem, rw_wb;
   logic [1:0]            src_ex;

   hz_state_e state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic       lw_hz, stall, bubble;
   fwd_sel_e   fwd_a, fwd_b;

   // The bubble is raw (not reset-gated); the shadow clears itself on reset.
   assign bubble = i_pc_src_EX | stall;

   hazard_shadow_pipe #(.REG_ADDR_W(REG_ADDR_W)) u_shadow (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_bubble        (bubble),
      .i_rs1_ID        (i_rs1_ID),
      .i_rs2_ID        (i_rs2_ID),
      .i_rd_ID         (i_rd_ID),
      .i_reg_write_ID  (i_reg_write_ID),
      .i_result_src_ID (i_result_src_ID),
      .o_rs1_EX        (rs1_ex),
      .o_rs2_EX        (rs2_ex),
      .o_rd_EX         (rd_ex),
      .o_reg_write_EX  (rw_ex),
      .o_result_src_EX (src_ex),
      .o_rd_MEM        (rd_mem),
      .o_reg_write_MEM (rw_mem),
      .o_rd_WB         (rd_wb),
      .o_reg_write_WB  (rw_wb)
   );

   function automatic fwd_sel_e fwd_pick(
      input logic [REG_ADDR_W-1:0] src,
      input logic                  mem_rw,
      input logic [REG_ADDR_W-1:0] mem_rd,
      input logic                  wb_rw,
      input logic [REG_ADDR_W-1:0] wb_rd
   );
      if (mem_rw && (mem_rd != '0) && (mem_rd == src)) return FWD_MEM;
      if (wb_rw && (wb_rd != '0) && (wb_rd == src))    return FWD_WB;
      return FWD_RF;
   endfunction

   // Load-use detect, stall FSM next state and the stall request.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall   = 1'b0;
      lw_hz   = (state_q == S_RUN) && rw_ex && (src_ex == RESULT_SRC_LOAD) &&
                (rd_ex != '0) && ((rd_ex == i_rs1_ID) || (rd_ex == i_rs2_ID));
      case (state_q)
         S_RUN: begin
            stall = lw_hz;
            if (lw_hz && !i_pc_src_EX && (LOAD_STALL > 1)) begin
               state_d = S_STALL;
               cnt_d   = 3'(LOAD_STALL - 1);
            end
         end
         S_STALL: begin
            stall = 1'b1;
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_d = S_RUN;
         end
         default: begin
            state_d = S_RUN;
            cnt_d   = '0;
         end
      endcase
      // A redirect kills the stalled instruction, so the stall is moot.
      if (i_pc_src_EX) begin
         state_d = S_RUN;
         cnt_d   = '0;
      end
   end

   // Stall FSM state register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // EX operand forwarding, MEM result preferred over WB.
   always_comb begin
      fwd_a = fwd_pick(rs1_ex, rw_mem, rd_mem, rw_wb, rd_wb);
      fwd_b = fwd_pick(rs2_ex, rw_mem, rd_mem, rw_wb, rd_wb);
   end

   // Pipeline control outputs; everything held low during reset.
   always_comb begin
      o_stall_IF    = 1'b0;
      o_stall_ID    = 1'b0;
      o_flush_ID    = 1'b0;
      o_flush_EX    = 1'b0;
      o_forwardA_EX = FWD_RF;
      o_forwardB_EX = FWD_RF;
      if (!i_rst) begin
         o_stall_IF    = stall & ~i_pc_src_EX;
         o_stall_ID    = stall & ~i_pc_src_EX;
         o_flush_ID    = i_pc_src_EX;
         o_flush_EX    = bubble;
         o_forwardA_EX = fwd_a;
         o_forwardB_EX = fwd_b;
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed table (LOAD_STALL=1), directed LOAD_STALL=3
// corner sequences, then random traffic against a bubble-count reference model.
module tb_hazard_unit;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       rw;
      logic [1:0] src;
   } id_t;

   typedef struct {
      id_t        id;
      logic       pc;
      logic [7:0] exp;
   } vec_t;

   logic i_clk;
   id_t  id_in;
   logic pc_in, rst_in;

   logic st_if1, st_id1, fl_id1, fl_ex1;
   logic [1:0] fa1, fb1;
   logic st_if3, st_id3, fl_id3, fl_ex3;
   logic [1:0] fa3, fb3;
   logic [7:0] out1, out3;

   int checks = 0;
   int errors = 0;

   hazard_unit #(.REG_ADDR_W(5), .LOAD_STALL(1)) dut1 (
      .i_clk(i_clk), .i_rst(rst_in),
      .i_rs1_ID(id_in.rs1), .i_rs2_ID(id_in.rs2), .i_rd_ID(id_in.rd),
      .i_reg_write_ID(id_in.rw), .i_result_src_ID(id_in.src), .i_pc_src_EX(pc_in),
      .o_stall_IF(st_if1), .o_stall_ID(st_id1), .o_flush_ID(fl_id1), .o_flush_EX(fl_ex1),
      .o_forwardA_EX(fa1), .o_forwardB_EX(fb1)
   );

   hazard_unit #(.REG_ADDR_W(5), .LOAD_STALL(3)) dut3 (
      .i_clk(i_clk), .i_rst(rst_in),
      .i_rs1_ID(id_in.rs1), .i_rs2_ID(id_in.rs2), .i_rd_ID(id_in.rd),
      .i_reg_write_ID(id_in.rw), .i_result_src_ID(id_in.src), .i_pc_src_EX(pc_in),
      .o_stall_IF(st_if3), .o_stall_ID(st_id3), .o_flush_ID(fl_id3), .o_flush_EX(fl_ex3),
      .o_forwardA_EX(fa3), .o_forwardB_EX(fb3)
   );

   assign out1 = {st_if1, st_id1, fl_id1, fl_ex1, fa1, fb1};
   assign out3 = {st_if3, st_id3, fl_id3, fl_ex3, fa3, fb3};

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Reference model: per configuration, the three shadow stages plus the
   // number of load-use bubbles still owed after the current cycle.
   int   LS [2] = '{1, 3};
   id_t  m_ex [2];
   id_t  m_mem [2];
   id_t  m_wb [2];
   int   m_left [2] = '{0, 0};

   function automatic id_t mk(int rs1, int rs2, int rd, int rw, int src);
      id_t v;
      v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd); v.rw = 1'(rw); v.src = 2'(src);
      return v;
   endfunction

   function automatic logic [7:0] ex8(logic st, logic fid, logic fex, logic [1:0] fa, logic [1:0] fb);
      return {st, st, fid, fex, fa, fb};
   endfunction

   function automatic bit m_hz(int k);
      return (m_left[k] == 0) && m_ex[k].rw && (m_ex[k].src == 2'b01) && (m_ex[k].rd != 0) &&
             ((m_ex[k].rd == id_in.rs1) || (m_ex[k].rd == id_in.rs2));
   endfunction

   function automatic logic [1:0] m_fwd(int k, logic [4:0] r);
      if (m_mem[k].rw && (m_mem[k].rd != 0) && (m_mem[k].rd == r)) return 2'b10;
      if (m_wb[k].rw && (m_wb[k].rd != 0) && (m_wb[k].rd == r))    return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [7:0] m_exp(int k);
      bit sreq;
      if (rst_in) return 8'h00;
      sreq = m_hz(k) || (m_left[k] > 0);
      return ex8(sreq && !pc_in, pc_in, pc_in || sreq, m_fwd(k, m_ex[k].rs1), m_fwd(k, m_ex[k].rs2));
   endfunction

   task automatic model_update();
      for (int k = 0; k < 2; k++) begin
         if (rst_in) begin
            m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; m_left[k] = 0;
         end else begin
            bit hz, sreq;
            hz   = m_hz(k);
            sreq = hz || (m_left[k] > 0);
            if (pc_in)              m_left[k] = 0;
            else if (m_left[k] > 0) m_left[k] = m_left[k] - 1;
            else if (hz)            m_left[k] = LS[k] - 1;
            m_wb[k]  = m_mem[k];
            m_mem[k] = m_ex[k];
            m_ex[k]  = (pc_in || sreq) ? id_t'(0) : id_in;
         end
      end
   endtask

   task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got {stIF,stID,flID,flEX,fA,fB}=%b expected %b", nm, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      model_update();
      #1;
   endtask

   // which: 0 = check the LOAD_STALL=1 instance, 1 = the LOAD_STALL=3 instance.
   task automatic run_cyc(id_t id, logic pc, logic rst, int which, logic [7:0] exp, string nm);
      id_in  = id;
      pc_in  = pc;
      rst_in = rst;
      @(negedge i_clk);
      if (which == 0) chk(nm, out1, exp);
      else            chk(nm, out3, exp);
      tick();
   endtask

   task automatic do_reset(int n);
      id_in  = '0;
      pc_in  = 1'b0;
      rst_in = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge i_clk);
         chk("reset_ls1", out1, 8'h00);
         chk("reset_ls3", out3, 8'h00);
         tick();
      end
      rst_in = 1'b0;
   endtask

   vec_t tbl[$];

   task automatic add_vec(id_t id, logic pc, logic [7:0] exp);
      vec_t v;
      v.id = id; v.pc = pc; v.exp = exp;
      tbl.push_back(v);
   endtask

   initial begin
      id_in  = '0;
      pc_in  = 1'b0;
      rst_in = 1'b1;

      // LOAD_STALL=1 directed table, one entry per cycle from a clean reset.
      add_vec(mk( 1, 2, 5, 1, 0), 0, ex8(0, 0, 0, 2'b00, 2'b00)); // add x5
      add_vec(mk( 5, 3, 7, 1, 0), 0, ex8(0, 0, 0, 2'b00, 2'b00)); // uses x5 (rs1)
      add_vec(mk( 8, 5, 9, 1, 0), 0, ex8(0, 0, 0, 2'b10, 2'b00)); // uses x5 (rs2); MEM fwd A
      add_vec(mk( 0, 0, 0, 0, 0), 0, ex8(0, 0, 0, 2'b00, 2'b01)); // WB fwd B
      add_vec(mk(10, 0, 6, 1, 1), 0, ex8(0, 0, 0, 2'b00, 2'b00)); // lw x6
      add_vec(mk(11, 6,12, 1, 0), 0, ex8(1, 0, 1, 2'b00, 2'b00)); // load-use stall
      add_vec(mk(11, 6,12, 1, 0), 0, ex8(0, 0, 0, 2'b00, 2'b00)); // released
      add_vec(mk( 0, 0, 0, 0, 0), 0, ex8(0, 0, 0, 2'b00, 2'b01)); // consumer gets WB
      add_vec(mk( 1, 0, 4, 1, 1), 0, ex8(0, 0, 0, 2'b00, 2'b00)); // lw x4
      add_vec(mk( 4, 0,13, 1, 0), 1, ex8(0, 1, 1, 2'b00, 2'b00)); // hazard + redirect
      add_vec(mk( 0, 0, 0, 0, 0), 0, ex8(0, 0, 0, 2'b00, 2'b00)); // no stall after
      add_vec(mk( 2, 0, 0, 1, 1), 0, ex8(0, 0, 0, 2'b00, 2'b00)); // lw x0
      add_vec(mk( 0, 0,14, 1, 0), 0, ex8(0, 0, 0, 2'b00, 2'b00)); // rs1=0: no stall
      add_vec(mk( 3, 0, 0, 1, 0), 0, ex8(0, 0, 0, 2'b00, 2'b00)); // add x0; x0 not fwd
      add_vec(mk( 0, 0, 0, 0, 0), 0, ex8(0, 0, 0, 2'b00, 2'b00));
      add_vec(mk( 0, 0, 0, 0, 0), 0, ex8(0, 0, 0, 2'b00, 2'b00));
      add_vec(mk( 0, 0, 7, 1, 0), 0, ex8(0, 0, 0, 2'b00, 2'b00)); // add x7 (older)
      add_vec(mk( 0, 0, 7, 1, 0), 0, ex8(0, 0, 0, 2'b00, 2'b00)); // add x7 (newer)
      add_vec(mk( 7, 7, 1, 1, 0), 0, ex8(0, 0, 0, 2'b00, 2'b00)); // uses x7 twice
      add_vec(mk( 0, 0, 0, 0, 0), 0, ex8(0, 0, 0, 2'b10, 2'b10)); // MEM beats WB

      do_reset(2);
      foreach (tbl[i]) run_cyc(tbl[i].id, tbl[i].pc, 1'b0, 0, tbl[i].exp, $sformatf("tbl%0d", i));

      // LOAD_STALL=3: three consecutive stall cycles, then the RF holds the data.
      do_reset(1);
      run_cyc(mk(10, 0, 6, 1, 1), 0, 0, 1, ex8(0, 0, 0, 2'b00, 2'b00), "ls3_lw");
      run_cyc(mk(11, 6,12, 1, 0), 0, 0, 1, ex8(1, 0, 1, 2'b00, 2'b00), "ls3_st1");
      run_cyc(mk(11, 6,12, 1, 0), 0, 0, 1, ex8(1, 0, 1, 2'b00, 2'b00), "ls3_st2");
      run_cyc(mk(11, 6,12, 1, 0), 0, 0, 1, ex8(1, 0, 1, 2'b00, 2'b00), "ls3_st3");
      run_cyc(mk(11, 6,12, 1, 0), 0, 0, 1, ex8(0, 0, 0, 2'b00, 2'b00), "ls3_release");
      run_cyc(mk( 0, 0, 0, 0, 0), 0, 0, 1, ex8(0, 0, 0, 2'b00, 2'b00), "ls3_fwd_rf");

      // LOAD_STALL=3: redirect in the first stall cycle cancels the sequence.
      run_cyc(mk( 1, 0, 4, 1, 1), 0, 0, 1, ex8(0, 0, 0, 2'b00, 2'b00), "br_lw");
      run_cyc(mk( 4, 0,13, 1, 0), 1, 0, 1, ex8(0, 1, 1, 2'b00, 2'b00), "br_flush");
      run_cyc(mk( 4, 0,13, 1, 0), 0, 0, 1, ex8(0, 0, 0, 2'b00, 2'b00), "br_after");
      run_cyc(mk( 0, 0, 0, 0, 0), 0, 0, 1, ex8(0, 0, 0, 2'b01, 2'b00), "br_fwd_wb");

      // LOAD_STALL=3: one reset cycle while in the stall state.
      run_cyc(mk(10, 0, 6, 1, 1), 0, 0, 1, ex8(0, 0, 0, 2'b00, 2'b00), "rs_lw");
      run_cyc(mk(11, 6,12, 1, 0), 0, 0, 1, ex8(1, 0, 1, 2'b00, 2'b00), "rs_st1");
      run_cyc(mk(11, 6,12, 1, 0), 0, 1, 1, ex8(0, 0, 0, 2'b00, 2'b00), "rs_in_reset");
      run_cyc(mk(11, 6,12, 1, 0), 0, 0, 1, ex8(0, 0, 0, 2'b00, 2'b00), "rs_after");
      run_cyc(mk( 0, 0, 0, 0, 0), 0, 0, 1, ex8(0, 0, 0, 2'b00, 2'b00), "rs_no_fwd");

      // Random traffic on a small register set, both configurations vs model.
      do_reset(2);
      for (int n = 0; n < 600; n++) begin
         id_in  = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 1), $urandom_range(0, 3));
         pc_in  = ($urandom_range(0, 7) == 0);
         rst_in = ($urandom_range(0, 63) == 0);
         @(negedge i_clk);
         chk("rand_ls1", out1, m_exp(0));
         chk("rand_ls3", out3, m_exp(1));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline control block for the 5-stage core. It sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers and generates stall, flush and forwarding controls for them.
- It keeps its own shadow copy of destination and source information for the EX, MEM and WB stages. This shadow copy is fed from ID-stage decode and from the unit's own stall/flush decisions.
- It inserts load-use bubbles using a small stall FSM, flushes wrong-path instructions on a taken branch or jump, and selects EX-stage operand forwarding.

Parameters:
- REG_ADDR_W, 5, register-address width.
- LOAD_STALL, 1, bubble cycles inserted per load-use hazard. Legal range is 1..7.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_rs1_ID  in  REG_ADDR_W  rs1 of the instruction in ID.
- i_rs2_ID  in  REG_ADDR_W  rs2 of the instruction in ID.
- i_rd_ID  in  REG_ADDR_W  rd of the instruction in ID.
- i_reg_write_ID  in  1  ID instruction writes rd.
- i_result_src_ID  in  2  ID result source; 2'b01 = load.
- i_pc_src_EX  in  1  taken branch or jump resolved in EX this cycle.
- o_stall_IF  out  1  hold the PC.
- o_stall_ID  out  1  hold the IF/ID register.
- o_flush_ID  out  1  clear the IF/ID register.
- o_flush_EX  out  1  clear the ID/EX register (bubble).
- o_forwardA_EX  out  2  ALU operand A select.
- o_forwardB_EX  out  2  ALU operand B select.

Behaviour:
- Reset is synchronous and active-high on i_clk.
  - All shadow fields are cleared to 0.
  - The FSM goes to S_RUN and the stall counter goes to 0.
  - While i_rst=1, every output is forced to 0.
- Shadow pipeline: EX holds {rs1, rs2, rd, reg_write, result_src}; MEM and WB hold {rd, reg_write}. On each edge:
  - EX <= ID inputs, or a bubble (all 0) if o_flush_EX=1.
  - MEM <= EX.
  - WB <= MEM.
- Load-use detect (combinational), lw_hz, is true when all of the following hold:
  - FSM is in S_RUN;
  - EX.reg_write=1 and EX.result_src=2'b01;
  - EX.rd != 0;
  - EX.rd equals i_rs1_ID or i_rs2_ID.
- FSM states are S_RUN and S_STALL, with counter cnt of 3 bits.
  - In S_RUN: stall = lw_hz. If lw_hz && !i_pc_src_EX && LOAD_STALL>1, go to S_STALL with cnt=LOAD_STALL-1.
  - In S_STALL: stall=1. cnt decrements each cycle; when cnt==1, return to S_RUN.
  - If i_pc_src_EX=1 in any state: go to S_RUN, cnt=0.
- Control outputs (combinational, same cycle):
  - o_flush_ID = i_pc_src_EX.
  - o_flush_EX = i_pc_src_EX | stall.
  - o_stall_IF = o_stall_ID = stall & ~i_pc_src_EX. Flush wins over stall.
  - Total load-use penalty is exactly LOAD_STALL cycles.
- Forwarding for operand A (B is identical using EX.rs2):
  - 2'b10 if MEM.reg_write, MEM.rd != 0 and MEM.rd == EX.rs1.
  - Otherwise 2'b01 if WB.reg_write, WB.rd != 0 and WB.rd == EX.rs1.
  - Otherwise 2'b00.
  - MEM has priority over WB.
- Writes to x0 never cause a hazard and are never forwarded.
- The register file is write-through, so no WB-to-ID forwarding is generated here.
- The stall sequence only terminates early on a branch flush or on reset.

Decomposition:
- riscv_pkg holds:
  - RESULT_SRC_LOAD = 2'b01;
  - fwd_sel_e: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - hz_state_e: S_RUN, S_STALL.
- One sub-module, hazard_shadow_pipe, holds the EX/MEM/WB shadow registers, with a bubble input driven by o_flush_EX.
- FSM, detection and forwarding logic stay in hazard_unit.

Test Plan:
- Back-to-back ALU: ID add x5 (reg_write=1, rd=5), then next ID rs1=5 → when the consumer reaches EX, o_forwardA_EX=2'b10; one cycle later a consumer with rs2=5 gets o_forwardB_EX=2'b01; no stall.
- Load-use, LOAD_STALL=1: lw x6, then ID rs2=6 → o_stall_IF=o_stall_ID=o_flush_EX=1 for exactly 1 cycle; the consumer then gets o_forwardB_EX=2'b01.
- LOAD_STALL=3 with the same sequence → stall held for exactly 3 consecutive cycles, then S_RUN; forwarding 00 since the register file now holds the data.
- i_pc_src_EX=1 in the first stall cycle → o_flush_ID=o_flush_EX=1, o_stall_*=0, FSM returns to S_RUN; the next cycle has no stall.
- rd=0 cases: lw x0 followed by rs1=0, and add x0 followed by rs1=0 → no stall, forwards 2'b00.
- Assert i_rst for 1 cycle during S_STALL → all outputs 0 during reset; afterwards S_RUN, shadows cleared, no stall or forward until new instructions arrive.
